ether_bus_ctrl: RTL and testbench

Sequencer between the Ethernet receive path and the core register bus. Accepts 56-bit validated payloads from the MAC receiver and buffers them in a small FIFO. Issues one bus transaction per payload, waits for read responses with a timeout, and hands read replies to the MAC transmitter over a valid/ready handshake. Also keeps saturating drop and timeout counters for host-side diagnostics.

---
 rtl/ether_bus_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ether_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ether_bus_ctrl
// Description : Sequencer between the Ethernet receive path and the core
//               register bus. Buffers validated payloads in a FIFO, issues
//               one bus transaction per payload, waits for read responses
//               with a timeout and forwards read replies to the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module ether_bus_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] rx_payload,
  input  logic        rx_valid,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [31:0] tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [7:0]  drop_count,
  output logic [7:0]  timeout_count
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
  localparam int c_TW = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
  localparam logic [c_TW-1:0] c_TMAX  = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_RESP  = 2'd2,
    S_SEND_REPLY = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // FIFO entry: {addr[15:0], wdata[15:0], is_write}
  logic [32:0]     r_mem [0:FIFO_DEPTH-1];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  logic [15:0]     r_hold_addr;
  logic [15:0]     r_hold_wdata;
  logic            r_hold_rw;
  logic [15:0]     r_rdata;
  logic [c_TW-1:0] r_tcnt;
  logic [7:0]      r_drop_cnt;
  logic [7:0]      r_tmo_cnt;

  logic [7:0]  w_opcode;
  logic        w_legal;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_match;
  logic        w_expire;
  logic [32:0] w_entry;
  logic [32:0] w_head;
  logic        w_unused_payload;

  // The low payload field carries nothing this block needs.
  assign w_unused_payload = ^rx_payload[15:0];

  assign w_opcode = rx_payload[23:16];
  assign w_legal  = (w_opcode == 8'h00) || (w_opcode == 8'h01);
  assign w_entry  = {rx_payload[55:40], rx_payload[39:24], w_opcode[0]};
  assign w_head   = r_mem[r_rptr];
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push   = rx_valid && w_legal && ((r_count < c_DEPTH) || w_pop);
  assign w_drop   = rx_valid && !w_push;
  assign w_match  = valid_i && !rw_i && (addr_i == r_hold_addr);
  assign w_expire = (r_tcnt == c_TMAX);

  assign addr_o        = r_hold_addr;
  assign data_o        = r_hold_wdata;
  assign rw_o          = r_hold_rw;
  assign tx_data       = {r_hold_addr, r_rdata};
  assign drop_count    = r_drop_cnt;
  assign timeout_count = r_tmo_cnt;

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    w_next   = r_state;
    valid_o  = 1'b0;
    tx_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        valid_o = 1'b1;
        w_next  = r_hold_rw ? S_IDLE : S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (w_match)       w_next = S_SEND_REPLY;
        else if (w_expire) w_next = S_IDLE;
      end
      S_SEND_REPLY: begin
        tx_start = 1'b1;
        if (tx_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Holding register, response capture, timeout timer and diagnostics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_rw    <= 1'b0;
      r_rdata      <= '0;
      r_tcnt       <= '0;
      r_drop_cnt   <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      if (w_pop) begin
        r_hold_addr  <= w_head[32:17];
        r_hold_wdata <= w_head[16:1];
        r_hold_rw    <= w_head[0];
      end
      if (r_state == S_ISSUE) begin
        r_tcnt <= '0;
      end else if (r_state == S_WAIT_RESP) begin
        if (w_match) begin
          r_rdata <= data_i;
        end else if (w_expire) begin
          if (r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ether_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ether_bus_ctrl
// Description : Directed self-checking bench for ether_bus_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ether_bus_ctrl;

  localparam int c_DEPTH   = 4;
  localparam int c_TIMEOUT = 32;

  logic        clk;
  logic        rst_n;
  logic [55:0] rx_payload;
  logic        rx_valid;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;
  logic [15:0] addr_i;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic [31:0] tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [7:0]  drop_count;
  logic [7:0]  timeout_count;

  int checks   = 0;
  int failures = 0;
  int n_wait;

  ether_bus_ctrl #(
    .FIFO_DEPTH (c_DEPTH),
    .TIMEOUT    (c_TIMEOUT)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_payload    (rx_payload),
    .rx_valid      (rx_valid),
    .addr_o        (addr_o),
    .data_o        (data_o),
    .rw_o          (rw_o),
    .valid_o       (valid_o),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .rw_i          (rw_i),
    .valid_i       (valid_i),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_ready      (tx_ready),
    .drop_count    (drop_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one payload for one cycle; returns one cycle later.
  task automatic send(input logic [15:0] a, input logic [15:0] d, input logic [7:0] op);
    rx_payload = {a, d, op, 16'hC0DE};
    rx_valid   = 1'b1;
    step();
    rx_valid   = 1'b0;
  endtask

  // Step at least once, until valid_o is seen or the budget runs out.
  task automatic wait_issue(input int max_cycles, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid_o && n < max_cycles);
    chk("wait_issue", {31'd0, valid_o}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_payload = '0;
    rx_valid   = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    rw_i       = 1'b0;
    valid_i    = 1'b0;
    tx_ready   = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_valid_o",  {31'd0, valid_o}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_addr_o",   {16'd0, addr_o}, 32'd0);
    chk("rst_tx_data",  tx_data, 32'd0);
    chk("rst_drop",     {24'd0, drop_count}, 32'd0);
    chk("rst_tmo",      {24'd0, timeout_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single write: valid_o at t+2, then held bus values with valid_o low
    send(16'h0012, 16'hBEEF, 8'h01);
    chk("wr_t1_valid", {31'd0, valid_o}, 32'd0);
    step();
    chk("wr_valid",  {31'd0, valid_o}, 32'd1);
    chk("wr_addr",   {16'd0, addr_o}, 32'h0012);
    chk("wr_data",   {16'd0, data_o}, 32'hBEEF);
    chk("wr_rw",     {31'd0, rw_o}, 32'd1);
    step();
    chk("wr_pulse1", {31'd0, valid_o}, 32'd0);
    chk("wr_hold",   {16'd0, addr_o}, 32'h0012);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_no_tx", {31'd0, tx_start}, 32'd0);
    end

    // Read with response; non-matching returns are ignored
    send(16'h0034, 16'h0000, 8'h00);
    step();
    chk("rd_valid", {31'd0, valid_o}, 32'd1);
    chk("rd_addr",  {16'd0, addr_o}, 32'h0034);
    chk("rd_rw",    {31'd0, rw_o}, 32'd0);
    step();
    valid_i = 1'b1; addr_i = 16'h0035; data_i = 16'h5555; rw_i = 1'b0;
    step();
    chk("rd_mis_addr", {31'd0, tx_start}, 32'd0);
    addr_i = 16'h0034; rw_i = 1'b1;
    step();
    chk("rd_mis_rw", {31'd0, tx_start}, 32'd0);
    addr_i = 16'h0034; data_i = 16'h1234; rw_i = 1'b0;
    step();
    valid_i = 1'b0;
    chk("rd_tx_start", {31'd0, tx_start}, 32'd1);
    chk("rd_tx_data",  tx_data, 32'h0034_1234);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd_hold_start", {31'd0, tx_start}, 32'd1);
      chk("rd_hold_data",  tx_data, 32'h0034_1234);
    end
    tx_ready = 1'b1;
    chk("rd_accept_cycle", {31'd0, tx_start}, 32'd1);
    step();
    tx_ready = 1'b0;
    chk("rd_tx_drop", {31'd0, tx_start}, 32'd0);

    // Timeout: exactly TIMEOUT cycles in WAIT_RESP
    send(16'h0056, 16'h0000, 8'h00);
    step();
    chk("to_issue", {31'd0, valid_o}, 32'd1);
    for (int i = 0; i < c_TIMEOUT; i++) step();
    chk("to_before", {24'd0, timeout_count}, 32'd0);
    step();
    chk("to_after",    {24'd0, timeout_count}, 32'd1);
    chk("to_no_tx",    {31'd0, tx_start}, 32'd0);
    chk("to_no_valid", {31'd0, valid_o}, 32'd0);

    // Overflow: read stalls, six writes arrive, four queue, two drop
    send(16'h0100, 16'h0000, 8'h00);
    step();
    chk("ov_issue", {31'd0, valid_o}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      rx_payload = {16'h0200 + 16'(k), 16'hA000 + 16'(k), 8'h01, 16'h0000};
      rx_valid   = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    chk("ov_drop", {24'd0, drop_count}, 32'd2);
    wait_issue(c_TIMEOUT + 8, n_wait);
    chk("ov_first_lat", n_wait, c_TIMEOUT - 4);
    chk("ov_tmo", {24'd0, timeout_count}, 32'd2);
    chk("ov_addr0", {16'd0, addr_o}, 32'h0200);
    chk("ov_data0", {16'd0, data_o}, 32'hA000);
    for (int k = 1; k < 4; k++) begin
      wait_issue(8, n_wait);
      chk("ov_spacing", n_wait, 32'd2);
      chk("ov_addr", {16'd0, addr_o}, 32'h0200 + k);
      chk("ov_data", {16'd0, data_o}, 32'hA000 + k);
      chk("ov_rw",   {31'd0, rw_o}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ov_empty", {31'd0, valid_o}, 32'd0);
    end

    // Illegal opcode, then drop counter saturation
    send(16'h0300, 16'h1111, 8'h07);
    chk("il_drop", {24'd0, drop_count}, 32'd3);
    chk("il_no_bus_t1", {31'd0, valid_o}, 32'd0);
    step();
    chk("il_no_bus_t2", {31'd0, valid_o}, 32'd0);
    rx_payload = {16'h0301, 16'h2222, 8'hFF, 16'h0000};
    for (int i = 0; i < 251; i++) begin
      rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    chk("sat_254", {24'd0, drop_count}, 32'd254);
    for (int i = 0; i < 49; i++) begin
      rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    step();
    chk("sat_255", {24'd0, drop_count}, 32'd255);
    chk("sat_no_bus", {31'd0, valid_o}, 32'd0);

    // Reset during WAIT_RESP with a write queued behind the read
    send(16'h0400, 16'h0000, 8'h00);
    step();
    chk("mr_issue", {31'd0, valid_o}, 32'd1);
    send(16'h0500, 16'h7777, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mr_addr",  {16'd0, addr_o}, 32'd0);
    chk("mr_data",  {16'd0, data_o}, 32'd0);
    chk("mr_rw",    {31'd0, rw_o}, 32'd0);
    chk("mr_valid", {31'd0, valid_o}, 32'd0);
    chk("mr_tx",    {31'd0, tx_start}, 32'd0);
    chk("mr_txd",   tx_data, 32'd0);
    chk("mr_drop",  {24'd0, drop_count}, 32'd0);
    chk("mr_tmo",   {24'd0, timeout_count}, 32'd0);
    step();
    rst_n = 1'b1;
    valid_i = 1'b1; addr_i = 16'h0400; data_i = 16'h9999; rw_i = 1'b0;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_late_tx",  {31'd0, tx_start}, 32'd0);
      chk("mr_no_issue", {31'd0, valid_o}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
